// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder; master drives operands, slave is the adder.
// No storage: pure wiring, zero latency.
// Backpressure travels on in_ready (slave to master) and out_ready (master to slave).
interface pipelined_adder_if #(
    parameter int NUMBITS = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [NUMBITS-1:0] A;
    logic [NUMBITS-1:0] B;
    logic               carryin;
    logic               sub;
    logic               out_valid;
    logic               out_ready;
    logic [NUMBITS-1:0] result;
    logic               carryout;
    logic               overflow;

    modport master (
        output in_valid, A, B, carryin, sub, out_ready,
        input  in_ready, out_valid, result, carryout, overflow
    );

    modport slave (
        input  in_valid, A, B, carryin, sub, out_ready,
        output in_ready, out_valid, result, carryout, overflow
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract, carry chain cut into STAGES chunks; PIPELINED_ADDER_SAT_EN enables signed saturation.
// Latency STAGES register ranks from accept to registered result, one op per cycle.
// Whole pipeline freezes while out_valid && !out_ready; in_ready is the combinational inverse of that stall.
module pipelined_adder #(
    parameter int NUMBITS = 16,
    parameter int STAGES  = 4
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave io
);
    localparam int CHUNK = NUMBITS / STAGES;
    localparam int MSB   = NUMBITS - 1;

    logic [STAGES-1:0]              vld_q;
    logic [STAGES-1:0]              c_q;
    logic [STAGES-1:0][NUMBITS-1:0] a_q;
    logic [STAGES-1:0][NUMBITS-1:0] b_q;
    logic [STAGES-1:0][NUMBITS-1:0] s_q;
    logic                           ovf_q;

    logic [STAGES-1:0]              vld_in;
    logic [STAGES-1:0]              c_in;
    logic [STAGES-1:0]              c_d;
    logic [STAGES-1:0][NUMBITS-1:0] a_in;
    logic [STAGES-1:0][NUMBITS-1:0] b_in;
    logic [STAGES-1:0][NUMBITS-1:0] s_in;
    logic [STAGES-1:0][NUMBITS-1:0] s_d;
    logic [STAGES-1:0][NUMBITS-1:0] s_nxt;
    logic [STAGES-1:0][CHUNK:0]     part;
    logic [NUMBITS-1:0]             res_d;
    logic                           ovf_d;
    logic                           stall;
    logic                           unused_ops;

    assign stall       = vld_q[STAGES-1] & ~io.out_ready;
    assign io.in_ready = ~stall;

    // Subtraction is folded into the adder as A + ~B + 1 at the input boundary.
    always_comb begin
        vld_in    = '0;
        c_in      = '0;
        a_in      = '0;
        b_in      = '0;
        s_in      = '0;
        vld_in[0] = io.in_valid;
        a_in[0]   = io.A;
        b_in[0]   = io.sub ? ~io.B : io.B;
        c_in[0]   = io.sub | io.carryin;
        for (int k = 1; k < STAGES; k++) begin
            vld_in[k] = vld_q[k-1];
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            s_in[k]   = s_q[k-1];
            c_in[k]   = c_q[k-1];
        end
    end

    always_comb begin
        part = '0;
        c_d  = '0;
        s_d  = s_in;
        for (int k = 0; k < STAGES; k++) begin
            part[k] = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
                    + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, c_in[k]};
            s_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
            c_d[k] = part[k][CHUNK];
        end
    end

    // Carry into the MSB is recovered as a^b^sum at that bit, so no extra carry tap is needed.
    always_comb begin
        ovf_d = c_d[STAGES-1] ^ a_in[STAGES-1][MSB] ^ b_in[STAGES-1][MSB] ^ s_d[STAGES-1][MSB];
        res_d = s_d[STAGES-1];
`ifdef PIPELINED_ADDER_SAT_EN
        if (ovf_d) begin
            res_d = a_in[STAGES-1][MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
        end
`endif
        s_nxt             = s_d;
        s_nxt[STAGES-1]   = res_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            c_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            ovf_q <= 1'b0;
        end else if (!stall) begin
            vld_q <= vld_in;
            c_q   <= c_d;
            a_q   <= a_in;
            b_q   <= b_in;
            s_q   <= s_nxt;
            ovf_q <= ovf_d;
        end
    end

    // Operand delay slots of the last rank have no consumer; synthesis trims them.
    assign unused_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};

    assign io.out_valid = vld_q[STAGES-1];
    assign io.result    = s_q[STAGES-1];
    assign io.carryout  = c_q[STAGES-1];
    assign io.overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Randomized and directed bench for pipelined_adder against an arithmetic reference model.
module tb_pipelined_adder;
    localparam int W  = 16;
    localparam int S  = 4;
    localparam int NV = 12;

`ifdef PIPELINED_ADDER_SAT_EN
    localparam logic [W-1:0] POS_OVF = 16'h7FFF;
    localparam logic [W-1:0] NEG_OVF = 16'h8000;
`else
    localparam logic [W-1:0] POS_OVF = 16'h8000;
    localparam logic [W-1:0] NEG_OVF = 16'h7FFF;
`endif

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } out_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    out_t exp_q[$];
    out_t got_q[$];

    always #5 clk = ~clk;

    pipelined_adder_if #(.NUMBITS(W)) io ();

    pipelined_adder #(.NUMBITS(W), .STAGES(S)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    function automatic out_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        out_t o;
        int   ua, ub, sa, sb, exact;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            o.co  = (ua >= ub);
            o.res = W'(ua - ub);
            exact = sa - sb;
        end else begin
            o.co  = (ua + ub + int'(cin)) >= (1 << W);
            o.res = W'(ua + ub + int'(cin));
            exact = sa + sb + int'(cin);
        end
        o.ov = (exact > (1 << (W-1)) - 1) || (exact < -(1 << (W-1)));
`ifdef PIPELINED_ADDER_SAT_EN
        if (o.ov) o.res = (exact > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
        return o;
    endfunction

    function automatic vec_t dvec(input int i);
        case (i)
            0:  return '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
            1:  return '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
            2:  return '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
            3:  return '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
            4:  return '{16'h7FFF, 16'h0001, 1'b0, 1'b0, POS_OVF,  1'b0, 1'b1};
            5:  return '{16'h8000, 16'hFFFF, 1'b0, 1'b0, NEG_OVF,  1'b1, 1'b1};
            6:  return '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
            7:  return '{16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0};
            8:  return '{16'h8000, 16'h0001, 1'b0, 1'b1, NEG_OVF,  1'b1, 1'b1};
            9:  return '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, POS_OVF,  1'b0, 1'b1};
            10: return '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
            default: return '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        endcase
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic drive_rand();
        io.A       = rand_op();
        io.B       = rand_op();
        io.carryin = 1'($urandom_range(0, 1));
        io.sub     = 1'($urandom_range(0, 1));
    endtask

    // Transfers are decided at the negedge; inputs only change just after a posedge.
    always @(negedge clk) begin
        if (!rst) begin
            if (io.in_valid && io.in_ready) exp_q.push_back(model(io.A, io.B, io.carryin, io.sub));
            if (io.out_valid && io.out_ready) begin
                out_t r;
                r.res = io.result;
                r.co  = io.carryout;
                r.ov  = io.overflow;
                got_q.push_back(r);
            end
        end
    end

    task automatic test_reset();
        io.in_valid = 1'b0; io.out_ready = 1'b0;
        io.A = '0; io.B = '0; io.carryin = 1'b0; io.sub = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (io.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", io.out_valid); end
        total++; if (io.result !== '0) begin bad++; $display("FAIL reset_result: got %h want 0000", io.result); end
        total++; if (io.carryout !== 1'b0) begin bad++; $display("FAIL reset_carryout: got %b want 0", io.carryout); end
        total++; if (io.overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", io.overflow); end
        total++; if (io.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", io.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (io.in_ready !== 1'b1 || io.out_valid !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle: in_ready=%b out_valid=%b want 1/0", io.in_ready, io.out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        for (int i = 0; i < NV; i++) begin
            vec_t v;
            int   lat;
            bit   seen;
            v = dvec(i);
            io.A = v.a; io.B = v.b; io.carryin = v.cin; io.sub = v.sub;
            io.in_valid = 1'b1; io.out_ready = 1'b1;
            lat = 0; seen = 1'b0;
            while (!seen && lat < 20) begin
                @(posedge clk); #1;
                io.in_valid = 1'b0;
                lat++;
                @(negedge clk);
                if (io.out_valid) seen = 1'b1;
            end
            total++; if (lat != S || !seen) begin bad++; $display("FAIL dir%0d_latency: got %0d cycles want %0d", i, lat, S); end
            total++; if (io.result !== v.res) begin bad++; $display("FAIL dir%0d_result: got %h want %h", i, io.result, v.res); end
            total++; if (io.carryout !== v.co) begin bad++; $display("FAIL dir%0d_carryout: got %b want %b", i, io.carryout, v.co); end
            total++; if (io.overflow !== v.ov) begin bad++; $display("FAIL dir%0d_overflow: got %b want %b", i, io.overflow, v.ov); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int   idx = 0;
        int   cyc = 0;
        bit   acc;
        bit   prev_stall = 1'b0;
        out_t snap = '0;
        exp_q.delete(); got_q.delete();
        io.out_ready = 1'b1;
        drive_rand();
        io.in_valid = 1'b1;
        while ((idx < 8 || got_q.size() < 8) && cyc < 60) begin
            @(negedge clk);
            acc = io.in_valid && io.in_ready;
            if (!io.out_ready) begin
                total++; if (io.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready_stall c%0d: got %b want 0", cyc, io.in_ready); end
                total++; if (io.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_out_valid_stall c%0d: got %b want 1", cyc, io.out_valid); end
                if (prev_stall) begin
                    total++; if ({io.result, io.carryout, io.overflow} !== snap) begin
                        bad++; $display("FAIL b2b_hold c%0d: got %h want %h", cyc, {io.result, io.carryout, io.overflow}, snap);
                    end
                end
                snap = {io.result, io.carryout, io.overflow};
                prev_stall = 1'b1;
            end else begin
                prev_stall = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 8) drive_rand();
                else io.in_valid = 1'b0;
            end
            io.out_ready = !(cyc >= 6 && cyc <= 8);
        end
        total++; if (got_q.size() != 8 || exp_q.size() != 8) begin
            bad++; $display("FAIL b2b_count: got %0d results %0d accepts want 8", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < 8 && i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_op%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        io.in_valid = 1'b0; io.out_ready = 1'b1;
    endtask

    task automatic test_random();
        int n_ops = 200;
        int sent = 0;
        int budget = 0;
        bit acc;
        exp_q.delete(); got_q.delete();
        io.out_ready = 1'b1;
        drive_rand();
        io.in_valid = 1'b1;
        while (sent < n_ops && budget < 5000) begin
            @(negedge clk);
            acc = io.in_valid && io.in_ready;
            if (acc) sent++;
            @(posedge clk); #1;
            budget++;
            if (acc || !io.in_valid) begin
                io.in_valid = (sent < n_ops) && ($urandom_range(0, 9) < 7);
                drive_rand();
            end
            io.out_ready = $urandom_range(0, 9) < 7;
        end
        io.in_valid = 1'b0; io.out_ready = 1'b1;
        budget = 0;
        while (got_q.size() < n_ops && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        total++; if (got_q.size() != n_ops || exp_q.size() != n_ops) begin
            bad++; $display("FAIL rand_count: got %0d results %0d accepts want %0d", got_q.size(), exp_q.size(), n_ops);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin
                bad++; $display("FAIL rand_op%0d: got res=%h co=%b ov=%b want res=%h co=%b ov=%b",
                                i, got_q[i].res, got_q[i].co, got_q[i].ov, exp_q[i].res, exp_q[i].co, exp_q[i].ov);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit   seen = 1'b0;
        int   budget = 0;
        out_t want;
        exp_q.delete(); got_q.delete();
        io.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_rand();
            io.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        io.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        total++; if (io.out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre_valid: got %b want 1", io.out_valid); end
        rst = 1'b1;
        #1;
        total++; if (io.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_drop: got %b want 0", io.out_valid); end
        total++; if (io.result !== '0) begin bad++; $display("FAIL rstmid_result: got %h want 0000", io.result); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        io.out_ready = 1'b1;
        exp_q.delete(); got_q.delete();
        repeat (12) begin
            @(negedge clk);
            if (io.out_valid) seen = 1'b1;
        end
        total++; if (seen || got_q.size() != 0) begin
            bad++; $display("FAIL rstmid_stale: out_valid seen=%b results=%0d want 0/0", seen, got_q.size());
        end
        @(posedge clk); #1;
        io.A = 16'h1111; io.B = 16'h2222; io.carryin = 1'b0; io.sub = 1'b0;
        io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        while (got_q.size() < 1 && budget < 20) begin
            @(posedge clk); #1;
            budget++;
        end
        want.res = 16'h3333; want.co = 1'b0; want.ov = 1'b0;
        total++; if (got_q.size() != 1 || got_q[0] !== want) begin
            bad++; $display("FAIL rstmid_fresh_op: results=%0d want 1 result 3333", got_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
